pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Sequencer for the MIPS inter-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  Generates the per-latch enable (i_valid) and flush (sync clear) and the PC enable.
//  Supports continuous run, single-step and HALT drain, plus load-use stall and branch flush.
//  Sits between the debug/command unit and the datapath latches.
// PARAMETERS
//  N_STAGES  4   number of pipeline latches; bit0 = IF/ID ... bit N_STAGES-1 = MEM/WB
//  CNT_W     32  width of the advance-cycle counter
// PORTS
//  i_clock            in   1         clock, all state updates on rising edge
//  i_reset            in   1         reset, synchronous, active-high
//  i_run_cmd          in   1         1-cycle pulse: start continuous run
//  i_step_cmd         in   1         1-cycle pulse: advance pipeline exactly one cycle
//  i_load_use_hazard  in   1         load-use hazard detected in ID (stall request)
//  i_branch_taken     in   1         taken branch/jump resolved this cycle (flush IF/ID)
//  i_halt_decoded     in   1         HALT instruction present in ID
//  o_pc_enable        out  1         PC register load enable
//  o_latch_valid      out  N_STAGES  per-latch enable
//  o_latch_flush      out  N_STAGES  per-latch sync clear (OR'd into latch reset; wins over valid)
//  o_state            out  3         IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4
//  o_halted           out  1         1 when state==HALTED
//  o_cycle_count      out  CNT_W     number of advance cycles since reset
// BEHAVIOUR
//  Reset: state=IDLE, drain counter=0, o_cycle_count=0; all outputs 0 while i_reset=1 and in IDLE.
//  Outputs are combinational from state + hazard inputs (same-cycle effect on latches).
//  "Advance cycle" = any cycle in RUN, STEP or DRAIN. In IDLE/HALTED: pc_enable=0, valid=0, flush=0.
//  Transitions:
//   IDLE:   run_cmd -> RUN; else step_cmd -> STEP (run_cmd wins if both).
//   RUN:    stays RUN; run_cmd/step_cmd ignored; halt_decoded -> DRAIN.
//   STEP:   exactly one advance cycle; next IDLE, or DRAIN if halt_decoded that cycle.
//   DRAIN:  lasts N_STAGES-1 cycles (counter loaded with N_STAGES-2 on entry, dec each cycle);
//           at counter==0 -> HALTED. Commands and hazard inputs ignored.
//   HALTED: absorbing; only i_reset leaves it.
//  Advance-cycle outputs in RUN/STEP, priority halt > load-use > branch > normal:
//   normal:    pc_enable=1, valid=all 1, flush=0.
//   load-use:  pc_enable=0, valid[0]=0 (IF/ID holds), flush[1]=1 (bubble into ID/EX),
//              valid[N-1:2]=1; branch_taken same cycle ignored (re-presented next cycle).
//   branch:    pc_enable=1, valid=all 1, flush[0]=1 (kill wrong-path fetch).
//   halt:      pc_enable=0, valid=all 1, flush[0]=1; HALT proceeds into ID/EX.
//  DRAIN outputs: pc_enable=0, valid=all 1, flush[0]=1 every cycle (bubbles behind HALT).
//  STEP with load-use still consumes the step (one stalled cycle, returns to IDLE).
//  o_cycle_count: +1 every advance cycle (incl. stalls, drain), saturates at all-ones.
//  Reset mid-RUN/DRAIN: next cycle IDLE, counters 0, all outputs 0.
// TESTING
//  1 reset, then 5 idle cycles -> state=0, pc_enable=0, valid=0000, flush=0000, count=0.
//  2 step_cmd pulse -> one cycle pc_enable=1, valid=1111, state=2; then state=0, count=1.
//  3 run_cmd, load_use=1 for 1 cycle -> pc_enable=0, valid=1110, flush=0010; next cycle normal.
//  4 RUN, load_use=1 and branch_taken=1 together -> load-use outputs only, flush=0010.
//  5 RUN, halt_decoded=1 at cycle t -> pc_enable=0, flush=0001 for t..t+3; state=4 at t+4, o_halted=1;
//    later run_cmd/step_cmd ignored, count frozen.
//  6 i_reset during DRAIN -> next cycle state=0, count=0; run_cmd then resumes RUN normally.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundles the command/hazard inputs and latch-control outputs of the
//   pipeline sequencer so the debug unit, the datapath and the sequencer
//   share one connection.
//   master : debug/command unit + hazard logic (drives commands, reads status)
//   slave  : pipeline_ctrl (reads commands/hazards, drives latch controls)
//   Signals:
//     i_run_cmd, i_step_cmd        1-cycle command pulses
//     i_load_use_hazard            stall request from ID
//     i_branch_taken               taken branch resolved this cycle
//     i_halt_decoded               HALT sitting in ID
//     o_pc_enable                  PC load enable
//     o_latch_valid[N_STAGES]      per-latch enable (bit0 = IF/ID)
//     o_latch_flush[N_STAGES]      per-latch sync clear, wins over valid
//     o_state[3]                   IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4
//     o_halted                     state == HALTED
//     o_cycle_count[CNT_W]         advance cycles since reset (saturating)
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 32
);
    logic                i_run_cmd;
    logic                i_step_cmd;
    logic                i_load_use_hazard;
    logic                i_branch_taken;
    logic                i_halt_decoded;
    logic                o_pc_enable;
    logic [N_STAGES-1:0] o_latch_valid;
    logic [N_STAGES-1:0] o_latch_flush;
    logic [2:0]          o_state;
    logic                o_halted;
    logic [CNT_W-1:0]    o_cycle_count;

    modport master (
        output i_run_cmd, i_step_cmd, i_load_use_hazard, i_branch_taken, i_halt_decoded,
        input  o_pc_enable, o_latch_valid, o_latch_flush, o_state, o_halted, o_cycle_count
    );

    modport slave (
        input  i_run_cmd, i_step_cmd, i_load_use_hazard, i_branch_taken, i_halt_decoded,
        output o_pc_enable, o_latch_valid, o_latch_flush, o_state, o_halted, o_cycle_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Sequencer for the MIPS inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   and the PC. Supports continuous run, single step and HALT drain, with
//   load-use stall and branch flush handled in the same cycle they are seen.
//   Ports:
//     i_clock   clock, rising edge
//     i_reset   synchronous, active-high reset; forces all outputs to 0
//     bus       pipeline_ctrl_if.slave (commands/hazards in, latch controls out)
//   Latch controls are combinational from the state register and the hazard
//   inputs so a stall or flush takes effect on the latches in the same cycle.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    // Drain counter only has to hold N_STAGES-2.
    localparam int DW = (N_STAGES > 2) ? $clog2(N_STAGES - 1) : 1;

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic             advance;

    assign advance = (state == RUN) || (state == STEP) || (state == DRAIN);

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned; otherwise synthesis infers latches.
    always_comb begin
        bus.o_pc_enable   = 1'b0;
        bus.o_latch_valid = '0;
        bus.o_latch_flush = '0;
        if (!i_reset) begin
            unique case (state)
                RUN, STEP: begin
                    if (bus.i_halt_decoded) begin
                        // HALT moves on into ID/EX; nothing new is fetched behind it.
                        bus.o_latch_valid    = '1;
                        bus.o_latch_flush[0] = 1'b1;
                    end else if (bus.i_load_use_hazard) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EX. A branch
                        // seen this cycle is re-presented once the stall clears.
                        bus.o_latch_valid    = '1;
                        bus.o_latch_valid[0] = 1'b0;
                        bus.o_latch_flush[1] = 1'b1;
                    end else begin
                        bus.o_pc_enable      = 1'b1;
                        bus.o_latch_valid    = '1;
                        bus.o_latch_flush[0] = bus.i_branch_taken;
                    end
                end
                DRAIN: begin
                    bus.o_latch_valid    = '1;
                    bus.o_latch_flush[0] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Status outputs read 0 while reset is held, matching the latch controls.
    assign bus.o_state       = i_reset ? 3'd0 : state;
    assign bus.o_halted      = !i_reset && (state == HALTED);
    assign bus.o_cycle_count = i_reset ? '0 : cycle_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // Reset is synchronous: it is just the highest-priority branch.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if (advance && (cycle_cnt != {CNT_W{1'b1}}))
                cycle_cnt <= cycle_cnt + CNT_W'(1);

            unique case (state)
                IDLE: begin
                    if (bus.i_run_cmd)
                        state <= RUN;
                    else if (bus.i_step_cmd)
                        state <= STEP;
                end
                RUN: begin
                    if (bus.i_halt_decoded) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(N_STAGES - 2);
                    end
                end
                STEP: begin
                    if (bus.i_halt_decoded) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(N_STAGES - 2);
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    // N_STAGES-1 drain cycles: counter runs N_STAGES-2 .. 0.
                    if (drain_cnt == '0)
                        state <= HALTED;
                    else
                        drain_cnt <= drain_cnt - DW'(1);
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios plus randomized commands/hazards, each cycle compared
//   against a behavioural model of the sequencer kept in this file.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
    localparam int N  = 4;
    localparam int CW = 32;
    localparam longint CNT_MAX = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.N_STAGES(N), .CNT_W(CW)) bus ();

    pipeline_ctrl #(.N_STAGES(N), .CNT_W(CW)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: what the pipeline is doing, not how it is encoded.
    bit     m_running    = 0;
    bit     m_stepping   = 0;
    int     m_drain_left = 0;
    bit     m_halted     = 0;
    longint m_count      = 0;

    logic [44:0] exp_vec;

    always @(posedge clk) begin
        if (rst) begin
            m_running = 0; m_stepping = 0; m_drain_left = 0; m_halted = 0; m_count = 0;
        end else begin
            if ((m_running || m_stepping || m_drain_left > 0) && m_count < CNT_MAX)
                m_count++;
            if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (m_running || m_stepping) begin
                if (bus.i_halt_decoded) begin
                    m_running = 0; m_stepping = 0; m_drain_left = N - 1;
                end else if (m_stepping) begin
                    m_stepping = 0;
                end
            end else if (!m_halted) begin
                if (bus.i_run_cmd) m_running = 1;
                else if (bus.i_step_cmd) m_stepping = 1;
            end
        end
    end

    function automatic logic [44:0] model_expect();
        logic pc; logic [N-1:0] v, f; logic [2:0] st; logic h;
        pc = 0; v = '0; f = '0; st = 3'd0; h = 0;
        if (rst) return '0;
        if (m_drain_left > 0) begin
            v = '1; f = N'(1); st = 3'd3;
        end else if (m_running || m_stepping) begin
            st = m_stepping ? 3'd2 : 3'd1;
            if (bus.i_halt_decoded) begin
                v = '1; f = N'(1);
            end else if (bus.i_load_use_hazard) begin
                v = ~N'(1); f = N'(2);
            end else begin
                pc = 1; v = '1; f = bus.i_branch_taken ? N'(1) : '0;
            end
        end else if (m_halted) begin
            st = 3'd4; h = 1;
        end
        return {pc, v, f, st, h, m_count[CW-1:0]};
    endfunction

    function automatic logic [44:0] obs_vec();
        return {bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush,
                bus.o_state, bus.o_halted, bus.o_cycle_count};
    endfunction

    // Drive one cycle of inputs at the falling edge; outputs settle by #1.
    task automatic drive(input bit r, input bit run, input bit step,
                         input bit lu, input bit br, input bit hl);
        @(negedge clk);
        rst                   = r;
        bus.i_run_cmd         = run;
        bus.i_step_cmd        = step;
        bus.i_load_use_hazard = lu;
        bus.i_branch_taken    = br;
        bus.i_halt_decoded    = hl;
        #1;
        exp_vec = model_expect();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1, 1);
        n_checks++;
        if (obs_vec() !== 45'd0) $display("FAIL reset_held obs=%h exp=0", obs_vec());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== 45'd0) $display("FAIL reset_idle%0d obs=%h exp=0", i, obs_vec());
            else n_pass++;
        end
    endtask

    task automatic test_step();
        drive(0, 0, 1, 0, 0, 0);   // IDLE cycle that takes the pulse
        drive(0, 0, 0, 0, 0, 0);   // the single advance cycle
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state} !== {1'b1, 4'b1111, 4'b0000, 3'd2})
            $display("FAIL step_adv obs=%h exp=%h", obs_vec(), {1'b1, 4'b1111, 4'b0000, 3'd2});
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.o_state, bus.o_pc_enable, bus.o_cycle_count} !== {3'd0, 1'b0, 32'd1})
            $display("FAIL step_done state=%0d pc=%b count=%0d exp state=0 pc=0 count=1",
                     bus.o_state, bus.o_pc_enable, bus.o_cycle_count);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec) $display("FAIL step_model obs=%h exp=%h", obs_vec(), exp_vec);
        else n_pass++;
    endtask

    task automatic test_load_use();
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush} !== {1'b0, 4'b1110, 4'b0010})
            $display("FAIL load_use pc=%b valid=%b flush=%b exp pc=0 valid=1110 flush=0010",
                     bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state} !== {1'b1, 4'b1111, 4'b0000, 3'd1})
            $display("FAIL after_stall obs=%h exp=%h", obs_vec(), exp_vec);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec) $display("FAIL load_use_model obs=%h exp=%h", obs_vec(), exp_vec);
        else n_pass++;
    endtask

    task automatic test_lu_branch();
        drive(0, 0, 1, 1, 1, 0);   // step_cmd ignored in RUN
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush} !== {1'b0, 4'b1110, 4'b0010})
            $display("FAIL lu_branch pc=%b valid=%b flush=%b exp pc=0 valid=1110 flush=0010",
                     bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0);
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state} !== {1'b1, 4'b1111, 4'b0001, 3'd1})
            $display("FAIL branch pc=%b valid=%b flush=%b state=%0d exp pc=1 valid=1111 flush=0001 state=1",
                     bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state);
        else n_pass++;
    endtask

    task automatic test_halt();
        logic [CW-1:0] frozen;
        for (int t = 0; t < 4; t++) begin
            // Only the first cycle presents HALT; hazards in DRAIN are ignored.
            drive(0, t == 2, t == 3, t >= 1, t >= 1, t == 0);
            n_checks++;
            if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state} !== {1'b0, 4'b1111, 4'b0001, (t == 0) ? 3'd1 : 3'd3})
                $display("FAIL halt_t%0d obs=%h exp=%h", t, obs_vec(), exp_vec);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.o_state, bus.o_halted, bus.o_pc_enable, bus.o_latch_valid} !== {3'd4, 1'b1, 1'b0, 4'b0000})
            $display("FAIL halted state=%0d halted=%b exp state=4 halted=1", bus.o_state, bus.o_halted);
        else n_pass++;
        frozen = m_count[CW-1:0];
        for (int i = 0; i < 4; i++) drive(0, i[0], ~i[0], 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.o_cycle_count !== frozen || bus.o_state !== 3'd4)
            $display("FAIL halt_frozen count=%0d state=%0d exp count=%0d state=4",
                     bus.o_cycle_count, bus.o_state, frozen);
        else n_pass++;
    endtask

    task automatic test_reset_drain();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.o_state !== 3'd3) $display("FAIL drain_entry state=%0d exp=3", bus.o_state);
        else n_pass++;
        drive(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== 45'd0) $display("FAIL reset_in_drain obs=%h exp=0", obs_vec());
        else n_pass++;
        drive(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== 45'd0) $display("FAIL post_reset obs=%h exp=0", obs_vec());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state, bus.o_cycle_count} !== {1'b1, 4'b1111, 4'b0000, 3'd1, 32'd0})
            $display("FAIL resume_run obs=%h exp pc=1 valid=1111 flush=0 state=1 count=0", obs_vec());
        else n_pass++;
    endtask

    task automatic test_step_load_use();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        n_checks++;
        if ({bus.o_pc_enable, bus.o_latch_valid, bus.o_latch_flush, bus.o_state} !== {1'b0, 4'b1110, 4'b0010, 3'd2})
            $display("FAIL step_stall obs=%h exp=%h", obs_vec(), exp_vec);
        else n_pass++;
        drive(0, 0, 0, 1, 0, 0);
        n_checks++;
        if ({bus.o_state, bus.o_latch_valid, bus.o_cycle_count} !== {3'd0, 4'b0000, 32'd1})
            $display("FAIL step_stall_done state=%0d valid=%b count=%0d exp state=0 valid=0000 count=1",
                     bus.o_state, bus.o_latch_valid, bus.o_cycle_count);
        else n_pass++;
    endtask

    task automatic test_random();
        bit r, run, step, lu, br, hl;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            run  = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 5) == 0);
            lu   = ($urandom_range(0, 3) == 0);
            br   = ($urandom_range(0, 3) == 0);
            hl   = ($urandom_range(0, 15) == 0);
            drive(r, run, step, lu, br, hl);
            n_checks++;
            if (obs_vec() !== exp_vec)
                $display("FAIL random_cyc%0d obs=%h exp=%h", i, obs_vec(), exp_vec);
            else n_pass++;
        end
    endtask

    initial begin
        bus.i_run_cmd         = 1'b0;
        bus.i_step_cmd        = 1'b0;
        bus.i_load_use_hazard = 1'b0;
        bus.i_branch_taken    = 1'b0;
        bus.i_halt_decoded    = 1'b0;
        test_reset();
        test_step();
        test_load_use();
        test_lu_branch();
        test_halt();
        test_reset_drain();
        test_step_load_use();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
